// File: rtl/oled_text_streamer.sv
`default_nettype none
// =============================================================================
// Module   : oled_text_streamer
// Brief    : ROWSxCOLS character frame buffer streamed byte-by-byte to oled_cntrl
//            with host write port, on-demand/auto refresh and row scrolling.
// Revision : 1.0  initial release
// =============================================================================
module oled_text_streamer #(
  parameter int COLS       = 16,
  parameter int ROWS       = 4,
  parameter int ADDR_W     = 6,
  parameter int AUTO_START = 1
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_refresh,
  input  logic              i_scroll_en,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_W:0]  c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ROW_W:0]   c_rows     = (ROW_W + 1)'(ROWS);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_EOF  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_buf [DEPTH];
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_pending;
  logic             r_auto;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row_ofs;
  logic             w_wr_hit;
  logic             w_start;
  logic             w_last;
  logic [ROW_W:0]   w_row_sum;
  logic [ROW_W-1:0] w_phys_row;
  logic [AW-1:0]    w_rd_addr;

  assign w_wr_hit = i_wr_en && ({1'b0, i_wr_addr} < c_depth);
  assign w_last   = (r_row == c_last_row) && (r_col == c_last_col);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (w_wr_hit) begin
      r_buf[i_wr_addr[AW-1:0]] <= i_wr_data;
    end
  end

  // Scrolled row = (row + row_ofs) mod ROWS; both operands are < ROWS so one subtract suffices.
  always_comb begin
    w_row_sum = {1'b0, r_row} + {1'b0, r_row_ofs};
    if (w_row_sum >= c_rows) begin
      w_row_sum = w_row_sum - c_rows;
    end
    w_phys_row = w_row_sum[ROW_W-1:0];
    w_rd_addr  = AW'(int'(w_phys_row) * COLS + int'(r_col));
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending || i_refresh || r_auto) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (i_done) begin
          w_state_nxt = w_last ? S_EOF : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_done) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_EOF:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_auto    <= (AUTO_START != 0);
      r_row     <= '0;
      r_col     <= '0;
      r_row_ofs <= '0;
    end else begin
      r_auto <= 1'b0;
      if (w_start) begin
        r_busy <= 1'b1;
        r_row  <= '0;
        r_col  <= '0;
      end
      if (r_state == S_LOAD) begin
        r_data  <= r_buf[w_rd_addr];
        r_valid <= 1'b1;
      end
      if (r_state == S_SEND && i_done) begin
        r_valid <= 1'b0;
        if (!w_last) begin
          if (r_col == c_last_col) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
      if (r_state == S_EOF) begin
        r_busy <= 1'b0;
        if (i_scroll_en) begin
          r_row_ofs <= (r_row_ofs == c_last_row) ? '0 : r_row_ofs + 1'b1;
        end
      end
      // One-deep request memory: refreshes seen while a frame runs collapse into one.
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (i_refresh && r_state != S_IDLE) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_frame_done = (r_state == S_EOF);

endmodule
`default_nettype wire
